// File: rtl/abs_val.sv
// Operand conditioning for the iterative signed divider: registers |N|, |D|,
// the quotient sign and divide-by-zero / most-negative status, one cycle after start.
module abs_val #(
  parameter int WIDTH = 32
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Np,
  output logic [WIDTH-1:0] Dp,
  output logic             sign,
  output logic             valid,
  output logic             dzero,
  output logic             nmin
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1),
  // which is exact once the result is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] ux;
    ux = x;
    return ux[WIDTH-1] ? (~ux + ONE) : ux;
  endfunction

  logic signed [WIDTH-1:0] n_p0, d_p0;
  logic [WIDTH-1:0]        nmag_p0, dmag_p0;
  logic                    sign_p0, dzero_p0, nmin_p0;

  logic [WIDTH-1:0]        nmag_p1, dmag_p1;
  logic                    sign_p1, dzero_p1, nmin_p1, vld_p1;

  // Stage p0: combinational negation and flag decode from the raw operands
  always_comb begin
    n_p0     = N;
    d_p0     = D;
    nmag_p0  = magnitude(n_p0);
    dmag_p0  = magnitude(d_p0);
    sign_p0  = n_p0[WIDTH-1] ^ d_p0[WIDTH-1];
    dzero_p0 = (D == '0);
    nmin_p0  = (N == MOST_NEG) | (D == MOST_NEG);
  end

  // Stage p1: output registers, loaded only on start
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      nmag_p1  <= '0;
      dmag_p1  <= '0;
      sign_p1  <= 1'b0;
      dzero_p1 <= 1'b0;
      nmin_p1  <= 1'b0;
    end else begin
      vld_p1 <= start;
      if (start) begin
        nmag_p1  <= nmag_p0;
        dmag_p1  <= dmag_p0;
        sign_p1  <= sign_p0;
        dzero_p1 <= dzero_p0;
        nmin_p1  <= nmin_p0;
      end
    end
  end

  assign Np    = nmag_p1;
  assign Dp    = dmag_p1;
  assign sign  = sign_p1;
  assign valid = vld_p1;
  assign dzero = dzero_p1;
  assign nmin  = nmin_p1;

endmodule

// File: tb/tb_abs_val.sv
// Bench for abs_val: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model.
module tb_abs_val;
  localparam int W = 32;

  logic         ck;
  logic         rst_n;
  logic         start;
  logic [W-1:0] n, d;
  logic [W-1:0] np, dp;
  logic         sign, valid, dzero, nmin;

  int errors = 0;
  int checks = 0;

  abs_val #(.WIDTH(W)) dut (
    .ck(ck), .rst_n(rst_n), .start(start), .N(n), .D(d),
    .Np(np), .Dp(dp), .sign(sign), .valid(valid), .dzero(dzero), .nmin(nmin)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Reference model: plain integer abs / sign XOR on the operands seen at each edge.
  logic [W-1:0] e_np, e_dp;
  logic         e_sign, e_valid, e_dzero, e_nmin;

  function automatic logic [W-1:0] ref_abs(input logic [W-1:0] v);
    longint s;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    return s[W-1:0];
  endfunction

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      e_np = '0; e_dp = '0; e_sign = 0; e_valid = 0; e_dzero = 0; e_nmin = 0;
    end else begin
      e_valid = (start === 1'b1);
      if (start === 1'b1) begin
        e_np    = ref_abs(n);
        e_dp    = ref_abs(d);
        e_sign  = ($signed(n) < 0) != ($signed(d) < 0);
        e_dzero = ($signed(d) == 0);
        e_nmin  = ($signed(n) == -(64'sd1 <<< (W-1))) || ($signed(d) == -(64'sd1 <<< (W-1)));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT against model.
  always @(negedge ck) begin
    chk("model.Np",    np,    e_np);
    chk("model.Dp",    dp,    e_dp);
    chk("model.sign",  sign,  e_sign);
    chk("model.valid", valid, e_valid);
    chk("model.dzero", dzero, e_dzero);
    chk("model.nmin",  nmin,  e_nmin);
  end

  task automatic expect_out(input string tag, input logic [W-1:0] xnp, input logic [W-1:0] xdp,
                            input logic xs, input logic xv, input logic xz, input logic xm);
    chk({tag, ".Np"}, np, xnp);
    chk({tag, ".Dp"}, dp, xdp);
    chk({tag, ".sign"}, sign, xs);
    chk({tag, ".valid"}, valid, xv);
    chk({tag, ".dzero"}, dzero, xz);
    chk({tag, ".nmin"}, nmin, xm);
  endtask

  // One start, then check the literal result one cycle later and the drop of valid after that.
  task automatic apply(input string tag, input logic [W-1:0] nn, input logic [W-1:0] dd,
                       input logic [W-1:0] xnp, input logic [W-1:0] xdp,
                       input logic xs, input logic xz, input logic xm);
    @(posedge ck); #1;
    start = 1'b1; n = nn; d = dd;
    @(posedge ck); #1;
    start = 1'b0;
    expect_out(tag, xnp, xdp, xs, 1'b1, xz, xm);
    @(posedge ck); #1;
    expect_out({tag, ".hold"}, xnp, xdp, xs, 1'b0, xz, xm);
  endtask

  logic [W-1:0] sn [4] = '{32'd1, -32'sd3, 32'd5, -32'sd7};
  logic [W-1:0] sd [4] = '{32'd2, 32'd4, -32'sd6, -32'sd8};
  logic [W-1:0] sp_n [4] = '{32'd1, 32'd3, 32'd5, 32'd7};
  logic [W-1:0] sp_d [4] = '{32'd2, 32'd4, 32'd6, 32'd8};
  logic         ss [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [W-1:0] edge_v [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0001};

  initial begin
    rst_n = 1'b0; start = 1'b0; n = '0; d = '0;
    #1;
    expect_out("reset", '0, '0, 0, 0, 0, 0);
    #11 rst_n = 1'b1;
    repeat (2) @(posedge ck);
    #1 expect_out("idle", '0, '0, 0, 0, 0, 0);

    apply("pp",   32'd100,        32'd7,          32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    apply("np",   32'hFFFF_FF9C,  32'd7,          32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    apply("pn",   32'd100,        -32'sd7,        32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    apply("nn",   -32'sd100,      -32'sd7,        32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    apply("min",  32'h8000_0000,  32'd1,          32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1);
    apply("max",  32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    apply("dz",   32'd5,          32'd0,          32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
    apply("nz",   32'd0,          -32'sd3,        32'd0, 32'd3, 1'b1, 1'b0, 1'b0);
    apply("dmin", 32'd9,          32'h8000_0000,  32'd9, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

    // Streaming: four back-to-back starts
    @(posedge ck); #1;
    start = 1'b1; n = sn[0]; d = sd[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge ck); #1;
      expect_out($sformatf("stream%0d", i), sp_n[i], sp_d[i], ss[i], 1'b1, 1'b0, 1'b0);
      if (i < 3) begin n = sn[i+1]; d = sd[i+1]; end
      else start = 1'b0;
    end
    @(posedge ck); #1;
    expect_out("stream.hold", 32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges clears everything at once
    #2 rst_n = 1'b0;
    #1 expect_out("areset", '0, '0, 0, 0, 0, 0);
    // Start sampled under reset is discarded
    start = 1'b1; n = 32'd11; d = 32'd3;
    @(posedge ck); #2;
    rst_n = 1'b1; start = 1'b0;
    @(posedge ck); #1;
    expect_out("discard", '0, '0, 0, 0, 0, 0);

    // Random stream with boundary operands and occasional mid-stream reset
    for (int i = 0; i < 10000; i++) begin
      @(posedge ck); #1;
      start = ($urandom_range(0, 3) != 0);
      n = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      d = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        start = 1'b1;
        @(posedge ck); #2;
        rst_n = 1'b1;
      end
    end
    @(posedge ck); #1 start = 1'b0;
    repeat (2) @(posedge ck);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/abs_val.md
# abs_val

Operand-conditioning stage in front of the iterative signed divider. Takes a signed dividend and divisor, and registers their unsigned magnitudes plus the quotient sign. The divider core can therefore run unsigned subtract-and-count, then negate the result when the sign is set. Single clock, one-cycle registered latency, with a valid handshake and status flags for divide-by-zero and most-negative operands.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- ck  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  operands on N/D are valid this cycle; capture them.
- N  input  WIDTH  dividend, two's complement signed.
- D  input  WIDTH  divisor, two's complement signed.
- Np  output  WIDTH  unsigned magnitude |N|.
- Dp  output  WIDTH  unsigned magnitude |D|.
- sign  output  1  quotient sign, N[WIDTH-1] XOR D[WIDTH-1].
- valid  output  1  one-cycle pulse: Np/Dp/sign/flags updated from the previous start.
- dzero  output  1  captured D equals 0.
- nmin  output  1  captured N or D equals the most-negative value, -2^(WIDTH-1).

## Operation
- On a rising ck with start=1:
  - Np <= N[WIDTH-1] ? (~N + 1) : N. Dp is computed the same way from D.
  - Magnitudes are unsigned WIDTH-bit values.
  - Most-negative input yields 2^(WIDTH-1), i.e. 0x8000_0000 for WIDTH=32. This is the correct unsigned magnitude and is not an error. nmin is set for it.
  - sign <= N[WIDTH-1] ^ D[WIDTH-1]. It is raw, with no zero special-casing: N=0 with D<0 gives sign=1. The downstream negation of 0 is 0, so this is harmless.
  - dzero <= (D == 0). The magnitudes are still computed, giving Dp=0.
  - nmin <= (N == 100..0) | (D == 100..0).
  - valid <= 1.
- On a rising ck with start=0:
  - valid <= 0.
  - Np, Dp, sign, dzero and nmin hold their last values.
- Back-to-back start is legal every cycle. Each start produces exactly one valid pulse one cycle later, carrying that start's operands. There is no busy or backpressure; the consumer must accept on valid.
- The negation path is purely combinational ahead of the output registers. No multi-cycle paths.

## Timing
- Latency: outputs reflect operands sampled at edge k immediately after edge k, so valid is high during cycle k+1. Throughput is 1 per cycle.
- Reset (rst_n=0, asynchronous): Np=0, Dp=0, sign=0, valid=0, dzero=0, nmin=0 immediately, independent of ck.
- Reset deassertion is synchronized externally. The first start is captured at the first rising ck with rst_n=1.
- Reset mid-operation: a start captured on the same edge rst_n is low is discarded, and no valid follows.
- If start is X or Z, behaviour is undefined. The bench drives start to 0 or 1 at all times after reset.

## Test plan
- Reset: assert rst_n=0 asynchronously between edges -> all outputs 0 at once; release, start=0 -> outputs stay 0, valid=0.
- Sign matrix:
  - N=100, D=7 -> Np=100, Dp=7, sign=0.
  - N=-100 (0xFFFF_FF9C), D=7 -> Np=100, sign=1.
  - N=100, D=-7 -> Dp=7, sign=1.
  - N=-100, D=-7 -> sign=0.
  - Each case: valid pulses exactly one cycle after start.
- Extremes:
  - N=0x8000_0000, D=1 -> Np=0x8000_0000, sign=1, nmin=1.
  - N=0x7FFF_FFFF, D=-1 -> Np=0x7FFF_FFFF, Dp=1, sign=1, nmin=0.
- Zero:
  - N=5, D=0 -> Dp=0, dzero=1, sign=0.
  - N=0, D=-3 -> Np=0, Dp=3, sign=1, dzero=0.
- Streaming: start held high for 4 cycles with pairs (1,2), (-3,4), (5,-6), (-7,-8) -> valid high 4 consecutive cycles with signs 0, 1, 1, 0 and matching magnitudes. Then start=0 -> valid=0, and outputs hold (7, 8, 0).
- Random: 10k random signed pairs, compared against a reference model of abs and XOR; reset is asserted randomly mid-stream, and no valid may follow a start that was sampled under reset.
